// File: rtl/color_state_decoder.sv
// color_state_decoder
//   Receiver-side decoder for the one-hot colour FSM state code (Blue=2'h1,
//   Red=2'h2). Locks onto the code stream, tracks the current colour,
//   measures run lengths, and buffers completed runs in a small FIFO that is
//   drained over a valid/ready handshake. Flags illegal codes, dropped records
//   and runs that exceed STUCK_LIMIT.
//
//   Ports
//     clk        : clock, rising edge
//     rst        : asynchronous active-low reset
//     code_valid : code is sampled this cycle
//     code       : state code (1=Blue, 2=Red, 0/3 illegal)
//     clr        : synchronous clear of err_code / overflow
//     run_valid  : FIFO head record valid
//     run_ready  : consumer accepts head record
//     run_state  : colour of head record (0=Blue, 1=Red)
//     run_len    : length of head record in valid samples
//     cur_state  : current decoded colour (0=Blue, 1=Red)
//     locked     : decoder is tracking a legal colour
//     toggle     : one-cycle pulse after a colour change
//     stuck      : current run length >= STUCK_LIMIT
//     err_code   : sticky, illegal code seen
//     overflow   : sticky, completed run dropped because FIFO was full
//
//   state       | meaning
//   ------------+-----------------------------------------------
//   ST_UNLOCKED | no legal colour tracked, counter held at 0
//   ST_BLUE     | tracking a Blue run, counter = samples so far
//   ST_RED      | tracking a Red run, counter = samples so far
module color_state_decoder #(
    parameter int CNT_WIDTH   = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int STUCK_LIMIT = 200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 code_valid,
    input  logic [1:0]           code,
    input  logic                 clr,
    output logic                 run_valid,
    input  logic                 run_ready,
    output logic                 run_state,
    output logic [CNT_WIDTH-1:0] run_len,
    output logic                 cur_state,
    output logic                 locked,
    output logic                 toggle,
    output logic                 stuck,
    output logic                 err_code,
    output logic                 overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] STUCK_LIM = CNT_WIDTH'(STUCK_LIMIT);
    localparam logic [CW-1:0]        FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_BLUE     = 2'd1,
        ST_RED      = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   toggle_q, toggle_d;
    logic                   err_code_q, err_code_d;
    logic                   overflow_q, overflow_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   mem_state_q [FIFO_DEPTH];
    logic [CNT_WIDTH-1:0]   mem_len_q   [FIFO_DEPTH];

    logic                   code_blue, code_red;
    logic                   push, push_state, push_acc, pop, full, err_set, ovf_set;

    assign code_blue = (code == 2'h1);
    assign code_red  = (code == 2'h2);

    // Run tracking FSM
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        toggle_d   = 1'b0;
        push       = 1'b0;
        push_state = 1'b0;
        err_set    = 1'b0;
        if (code_valid) begin
            case (state_q)
                ST_UNLOCKED: begin
                    if (code_blue) begin
                        state_d = ST_BLUE;
                        cnt_d   = CNT_ONE;
                    end else if (code_red) begin
                        state_d = ST_RED;
                        cnt_d   = CNT_ONE;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                ST_BLUE, ST_RED: begin
                    if ((state_q == ST_BLUE && code_blue) || (state_q == ST_RED && code_red)) begin
                        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
                    end else if (code_blue || code_red) begin
                        push       = 1'b1;
                        push_state = (state_q == ST_RED);
                        state_d    = code_red ? ST_RED : ST_BLUE;
                        cnt_d      = CNT_ONE;
                        toggle_d   = 1'b1;
                    end else begin
                        // partial run is discarded on an illegal code
                        state_d = ST_UNLOCKED;
                        cnt_d   = '0;
                        err_set = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_UNLOCKED;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // FIFO control; a push into a full FIFO is still accepted when the head
    // leaves in the same cycle, since the popped slot is the one overwritten.
    always_comb begin
        pop      = run_valid && run_ready;
        full     = (count_q == FULL_CNT);
        push_acc = push && (!full || pop);
        ovf_set  = push && full && !pop;
        wr_ptr_d = push_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push_acc, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // a set in the same cycle as clr wins
        err_code_d = err_set | (err_code_q & ~clr);
        overflow_d = ovf_set | (overflow_q & ~clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_UNLOCKED;
            cnt_q      <= '0;
            toggle_q   <= 1'b0;
            err_code_q <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_state_q[i] <= 1'b0;
                mem_len_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            toggle_q   <= toggle_d;
            err_code_q <= err_code_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            if (push_acc) begin
                mem_state_q[wr_ptr_q] <= push_state;
                mem_len_q[wr_ptr_q]   <= cnt_q;
            end
        end
    end

    assign locked    = (state_q != ST_UNLOCKED);
    assign cur_state = (state_q == ST_RED);
    assign stuck     = locked && (cnt_q >= STUCK_LIM);
    assign toggle    = toggle_q;
    assign err_code  = err_code_q;
    assign overflow  = overflow_q;
    assign run_valid = (count_q != '0);
    assign run_state = mem_state_q[rd_ptr_q];
    assign run_len   = mem_len_q[rd_ptr_q];

endmodule

// File: tb/tb_color_state_decoder.sv
`timescale 1ns/1ps
module tb_color_state_decoder;

    localparam int CNT_WIDTH   = 8;
    localparam int FIFO_DEPTH  = 4;
    localparam int STUCK_LIMIT = 200;
    localparam int LEN_MAX     = (1 << CNT_WIDTH) - 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 code_valid = 1'b0;
    logic [1:0]           code = 2'h0;
    logic                 clr = 1'b0;
    logic                 run_ready = 1'b0;
    logic                 run_valid, run_state, cur_state, locked, toggle, stuck, err_code, overflow;
    logic [CNT_WIDTH-1:0] run_len;

    color_state_decoder #(
        .CNT_WIDTH(CNT_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .STUCK_LIMIT(STUCK_LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .code_valid(code_valid), .code(code), .clr(clr),
        .run_valid(run_valid), .run_ready(run_ready), .run_state(run_state),
        .run_len(run_len), .cur_state(cur_state), .locked(locked), .toggle(toggle),
        .stuck(stuck), .err_code(err_code), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Behavioural model: colour as an int (-1 = not locked), true run length
    // as an unbounded int, completed runs as a queue of packed {colour, len}.
    int m_color = -1;
    int m_run   = 0;
    int m_q[$];
    bit m_err = 0, m_ovf = 0, m_tog = 0;
    bit chk_en = 0;

    function automatic int sat(input int v);
        return (v > LEN_MAX) ? LEN_MAX : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_color = -1; m_run = 0; m_q.delete();
        m_err = 0; m_ovf = 0; m_tog = 0;
    endtask

    task automatic model_step(input bit cv, input int c, input bit cl, input bit rdy);
        bit err_set = 0, ovf_set = 0, new_tog = 0, do_push = 0;
        int rec = 0;
        if (cv) begin
            if (c == 1 || c == 2) begin
                if (m_color < 0) begin
                    m_color = c - 1; m_run = 1;
                end else if (m_color == c - 1) begin
                    m_run++;
                end else begin
                    do_push = 1; rec = (m_color << 16) | sat(m_run);
                    m_color = c - 1; m_run = 1; new_tog = 1;
                end
            end else begin
                m_color = -1; m_run = 0; err_set = 1;
            end
        end
        if (rdy && m_q.size() > 0) void'(m_q.pop_front());
        if (do_push) begin
            if (m_q.size() < FIFO_DEPTH) m_q.push_back(rec);
            else ovf_set = 1;
        end
        m_err = err_set | (m_err & !cl);
        m_ovf = ovf_set | (m_ovf & !cl);
        m_tog = new_tog;
    endtask

    task automatic cycle(input bit cv, input logic [1:0] c, input bit cl, input bit rdy);
        code_valid = cv; code = c; clr = cl; run_ready = rdy;
        @(posedge clk); #1;
        model_step(cv, int'(c), cl, rdy);
    endtask

    // Compare process: DUT against model every cycle out of reset
    always @(negedge clk) begin
        if (chk_en && rst) begin
            chk("locked",    int'(locked),    int'(m_color >= 0));
            chk("cur_state", int'(cur_state), int'(m_color == 1));
            chk("stuck",     int'(stuck),     int'(m_color >= 0 && m_run >= STUCK_LIMIT));
            chk("toggle",    int'(toggle),    int'(m_tog));
            chk("err_code",  int'(err_code),  int'(m_err));
            chk("overflow",  int'(overflow),  int'(m_ovf));
            chk("run_valid", int'(run_valid), int'(m_q.size() > 0));
            if (m_q.size() > 0) begin
                chk("run_state", int'(run_state), m_q[0] >> 16);
                chk("run_len",   int'(run_len),   m_q[0] & 16'hffff);
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_run_valid"}, int'(run_valid), 0);
        chk({tag, "_run_state"}, int'(run_state), 0);
        chk({tag, "_run_len"},   int'(run_len),   0);
        chk({tag, "_cur_state"}, int'(cur_state), 0);
        chk({tag, "_locked"},    int'(locked),    0);
        chk({tag, "_toggle"},    int'(toggle),    0);
        chk({tag, "_stuck"},     int'(stuck),     0);
        chk({tag, "_err_code"},  int'(err_code),  0);
        chk({tag, "_overflow"},  int'(overflow),  0);
    endtask

    initial begin
        logic [1:0] prev;
        // reset
        #12;
        chk_all_zero("rst");
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        chk_en = 1;

        // 1,1,1,2 -> record {Blue,3}, toggle once, now Red
        cycle(1, 2'h1, 0, 0);
        chk("lock_after_1", int'(locked), 1);
        cycle(1, 2'h1, 0, 0);
        cycle(1, 2'h1, 0, 0);
        cycle(1, 2'h2, 0, 0);
        chk("t1_valid", int'(run_valid), 1);
        chk("t1_state", int'(run_state), 0);
        chk("t1_len",   int'(run_len),   3);
        chk("t1_tog",   int'(toggle),    1);
        chk("t1_cur",   int'(cur_state), 1);
        cycle(0, 2'h0, 0, 1);
        chk("t1_tog_off", int'(toggle), 0);
        chk("t1_empty",   int'(run_valid), 0);

        // Red x5 then Blue, held under backpressure
        repeat (4) cycle(1, 2'h2, 0, 0);
        cycle(1, 2'h1, 0, 0);
        repeat (3) begin
            cycle(0, 2'h0, 0, 0);
            chk("t2_valid", int'(run_valid), 1);
            chk("t2_state", int'(run_state), 1);
            chk("t2_len",   int'(run_len),   5);
        end
        cycle(0, 2'h0, 0, 1);
        chk("t2_empty", int'(run_valid), 0);

        // overflow: 6 colour changes with no drain
        for (int i = 0; i < 6; i++) cycle(1, (i % 2 == 0) ? 2'h2 : 2'h1, 0, 0);
        chk("t3_ovf",   int'(overflow), 1);
        chk("t3_head",  int'(run_len),  1);
        cycle(0, 2'h0, 1, 0);
        chk("t3_clr",   int'(overflow), 0);
        chk("t3_keep",  int'(run_valid), 1);
        for (int i = 0; i < 4; i++) cycle(0, 2'h0, 0, 1);
        chk("t3_drained", int'(run_valid), 0);

        // illegal code while locked in Blue
        cycle(1, 2'h1, 0, 0);
        cycle(1, 2'h1, 0, 0);
        cycle(1, 2'h3, 0, 0);
        chk("t4_unlock", int'(locked),    0);
        chk("t4_err",    int'(err_code),  1);
        chk("t4_nopush", int'(run_valid), 0);
        chk("t4_notog",  int'(toggle),    0);
        cycle(1, 2'h2, 0, 0);
        chk("t4_red",    int'(cur_state), 1);
        cycle(0, 2'h0, 1, 0);
        chk("t4_clr",    int'(err_code), 0);

        // long Blue run: stuck at 200, saturation at 255
        for (int i = 1; i <= 260; i++) begin
            cycle(1, 2'h1, 0, 1);
            if (i == 1) begin
                chk("t5_red1_state", int'(run_state), 1);
                chk("t5_red1_len",   int'(run_len),   1);
            end
            if (i == 199) chk("t5_stuck199", int'(stuck), 0);
            if (i == 200) chk("t5_stuck200", int'(stuck), 1);
        end
        cycle(1, 2'h2, 0, 0);
        chk("t5_len",   int'(run_len),   255);
        chk("t5_state", int'(run_state), 0);
        chk("t5_stuck", int'(stuck),     0);
        cycle(0, 2'h0, 0, 1);

        // gaps in code_valid during a Red run of 4 samples
        cycle(0, 2'h1, 0, 0);
        cycle(1, 2'h2, 0, 0);
        cycle(0, 2'h3, 0, 0);
        cycle(0, 2'h1, 0, 0);
        cycle(1, 2'h2, 0, 0);
        cycle(0, 2'h0, 0, 0);
        cycle(1, 2'h2, 0, 0);
        cycle(1, 2'h1, 0, 0);
        chk("t6_len",   int'(run_len),   4);
        chk("t6_state", int'(run_state), 1);
        cycle(0, 2'h0, 0, 1);

        // randomized traffic
        prev = 2'h1;
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] c;
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 4)       c = ($urandom_range(0, 1) == 0) ? 2'h0 : 2'h3;
            else if (r < 74) c = prev;
            else             c = (prev == 2'h1) ? 2'h2 : 2'h1;
            if (c == 2'h1 || c == 2'h2) prev = c;
            cycle($urandom_range(0, 3) != 0, c, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 2) == 0);
        end

        // reset mid-run with records buffered
        cycle(1, 2'h2, 0, 0);
        cycle(1, 2'h2, 0, 0);
        cycle(1, 2'h1, 0, 0);
        cycle(1, 2'h3, 0, 0);
        #2 rst = 1'b0;
        #1 chk_all_zero("midrst");
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        cycle(1, 2'h2, 0, 0);
        chk("relock",     int'(locked),    1);
        chk("relock_cur", int'(cur_state), 1);
        chk("relock_emp", int'(run_valid), 0);
        for (int i = 0; i < 40; i++)
            cycle($urandom_range(0, 1), 2'($urandom_range(1, 2)), 0, $urandom_range(0, 1));

        @(negedge clk);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
